// File: rtl/seq_div_u2.sv
// ============================================================================
//  Module   : seq_div_u2
//  Purpose  : Sequential signed radix-2 restoring divider, one quotient bit
//             per clock, start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_div_u2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] quo_q,       quo_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] dvs_q,       dvs_d;
    logic [WIDTH-1:0] dvd_q,       dvd_d;
    logic             sn_q,        sn_d;
    logic             sd_q,        sd_d;
    logic             dz_q,        dz_d;
    logic             ov_q,        ov_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_out_q,   dbz_out_d;
    logic             ovf_out_q,   ovf_out_d;
    logic             done_q,      done_d;

    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Magnitudes wrap naturally: |-2^(W-1)| stays 2^(W-1) as an unsigned value.
    assign w_dvd_abs = dividend[WIDTH-1] ? (~dividend + C_ONE) : dividend;
    assign w_dvs_abs = divisor[WIDTH-1]  ? (~divisor  + C_ONE) : divisor;

    // Borrow out of the trial subtraction decides the quotient bit.
    assign w_rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, dvs_q};
    assign w_fits   = ~w_diff[WIDTH];

    assign w_q_fix = (sn_q ^ sd_q) ? (~quo_q + C_ONE) : quo_q;
    assign w_r_fix = sn_q ? (~rem_q + C_ONE) : rem_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        sn_d        = sn_q;
        sd_d        = sd_q;
        dz_d        = dz_q;
        ov_d        = ov_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_out_d   = dbz_out_q;
        ovf_out_d   = ovf_out_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    quo_d   = w_dvd_abs;
                    dvs_d   = w_dvs_abs;
                    dvd_d   = dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                    sn_d    = dividend[WIDTH-1];
                    sd_d    = divisor[WIDTH-1];
                    dz_d    = (divisor == '0);
                    ov_d    = (dividend == C_MIN) && (divisor == '1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], w_fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    ovf_out_d   = 1'b0;
                end else begin
                    quotient_d  = w_q_fix;
                    remainder_d = w_r_fix;
                    ovf_out_d   = ov_q;
                end
                dbz_out_d = dz_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            sn_q        <= 1'b0;
            sd_q        <= 1'b0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_out_q   <= 1'b0;
            ovf_out_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            dvd_q       <= dvd_d;
            sn_q        <= sn_d;
            sd_q        <= sd_d;
            dz_q        <= dz_d;
            ov_q        <= ov_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_out_q   <= dbz_out_d;
            ovf_out_q   <= ovf_out_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_out_q;
    assign overflow    = ovf_out_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_div_u2.sv
// ============================================================================
//  Module   : tb_seq_div_u2
//  Purpose  : Scoreboard bench for seq_div_u2 (WIDTH=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_div_u2;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           dc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    seq_div_u2 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: truncating signed division with the divider's special cases.
    task automatic model(input int a, input int b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov);
        int qi;
        int ri;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            qi = -1;
            ri = a;
            dz = 1'b1;
        end else if (a == -8 && b == -1) begin
            qi = -8;
            ri = 0;
            ov = 1'b1;
        end else begin
            qi = a / b;
            ri = a % b;
        end
        q = W'(qi);
        r = W'(ri);
    endtask

    // Caller is at a negedge with the divider idle.
    task automatic issue(input int a, input int b,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dz, input logic ov);
        exp_t e;
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        #1;
        e.q  = q;
        e.r  = r;
        e.dz = dz;
        e.ov = ov;
        e.dc = cyc + W + 1;
        sb.push_back(e);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient",    {28'd0, quotient},    {28'd0, e.q});
                chk("remainder",   {28'd0, remainder},   {28'd0, e.r});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                chk("overflow",    {31'd0, overflow},    {31'd0, e.ov});
                chk("latency",     cyc,                  e.dc);
                chk("busy_at_done", {31'd0, busy},       32'd0);
            end
        end
    end

    initial begin
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic         mdz;
        logic         mov;
        int           ai;
        int           bi;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_q",    {28'd0, quotient}, 32'd0);
        chk("reset_r",    {28'd0, remainder}, 32'd0);
        chk("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);

        issue(7, 2, 4'b0011, 4'b0001, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);
        issue(-7, 2, 4'b1101, 4'b1111, 1'b0, 1'b0);
        wait_done();
        issue(7, -2, 4'b1101, 4'b0001, 1'b0, 1'b0);
        wait_done();
        issue(-8, -1, 4'b1000, 4'b0000, 1'b0, 1'b1);
        wait_done();
        issue(5, 0, 4'b1111, 4'b0101, 1'b1, 1'b0);
        wait_done();
        @(negedge clk);

        // Starts during a running op must be ignored.
        issue(7, 2, 4'b0011, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            start    = 1'b1;
            dividend = 4'd3;
            divisor  = 4'd1;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done();
        issue(-6, 4, 4'b1111, 4'b1110, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);

        // Reset mid-calculation aborts the op.
        issue(6, 3, 4'b0010, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_done",  {31'd0, done}, 32'd0);
        chk("abort_q",     {28'd0, quotient}, 32'd0);
        chk("abort_r",     {28'd0, remainder}, 32'd0);
        chk("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(-5, -2, 4'b0010, 4'b1111, 1'b0, 1'b0);
        wait_done();

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ai = (i > 7) ? i - 16 : i;
                bi = (j > 7) ? j - 16 : j;
                model(ai, bi, mq, mr, mdz, mov);
                issue(ai, bi, mq, mr, mdz, mov);
                wait_done();
            end
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
